// File: rtl/avalon_main_responder.sv
// Avalon-MM agent backed by a byte-maskable single-port RAM.
// Serves fixed-latency pipelined reads, unstalled writes, and flags out-of-range reads with SLVERR.
module avalon_main_responder #(
  parameter int unsigned MemWords    = 4096,
  parameter int unsigned ReadLatency = 2,
  parameter int unsigned MaxPending  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] avs_main_address,
  input  logic [3:0]  avs_main_byteenable,
  input  logic        avs_main_read,
  input  logic        avs_main_write,
  input  logic [31:0] avs_main_writedata,
  output logic        avs_main_waitrequest,
  output logic [31:0] avs_main_readdata,
  output logic        avs_main_readdatavalid,
  output logic [1:0]  avs_main_response
);

  localparam int unsigned AW = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int unsigned PW = $clog2(MaxPending + 1);

  logic [31:0]          mem_q [MemWords];
  logic [ReadLatency-1:0] vld_q;
  logic [ReadLatency-1:0] err_q;
  logic [31:0]          dat_q [ReadLatency];
  logic [PW-1:0]        pending_q, pending_d;

  logic          in_range;
  logic [AW-1:0] idx;
  logic          full;
  logic          rd_acc;
  logic          wr_en;
  logic          rdv;

  assign in_range = avs_main_address < 32'(MemWords);
  assign idx      = avs_main_address[AW-1:0];
  assign full     = pending_q == PW'(MaxPending);

  // No bypass: a read retiring this cycle does not free a slot until the next one.
  assign avs_main_waitrequest = avs_main_read & ~avs_main_write & full;

  assign rd_acc = avs_main_read & ~avs_main_write & ~full & rst_ni;
  assign wr_en  = avs_main_write & in_range & rst_ni;
  assign rdv    = vld_q[ReadLatency-1];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (avs_main_byteenable[i]) begin
          mem_q[idx][8*i +: 8] <= avs_main_writedata[8*i +: 8];
        end
      end
    end
  end

  // Data stages need no reset: the output is gated by the reset-cleared valid bits.
  always_ff @(posedge clk_i) begin
    if (rd_acc && in_range) begin
      dat_q[0] <= mem_q[idx];
    end
    for (int i = 1; i < ReadLatency; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  always_comb begin
    pending_d = pending_q;
    unique case ({rd_acc, rdv})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q     <= '0;
      err_q     <= '0;
      pending_q <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      err_q[0] <= rd_acc & ~in_range;
      for (int i = 1; i < ReadLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
      end
      pending_q <= pending_d;
    end
  end

  assign avs_main_readdatavalid = rdv;
  assign avs_main_readdata      = (rdv && !err_q[ReadLatency-1]) ? dat_q[ReadLatency-1] : '0;
  assign avs_main_response      = (rdv && err_q[ReadLatency-1]) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_avalon_main_responder.sv
// Directed bench: u0 uses default parameters, u1 uses MaxPending=2 / ReadLatency=4.
// Both instances share stimulus; each check targets the instance under test.
module tb_avalon_main_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        rd, wr;

  logic        wait0, rdv0, wait1, rdv1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  resp0, resp1;

  int total = 0;
  int bad   = 0;
  int issued, got;
  logic [17:0] exp_rdv_mask, exp_wait_mask;

  avalon_main_responder u0 (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .avs_main_address       (addr),
    .avs_main_byteenable    (be),
    .avs_main_read          (rd),
    .avs_main_write         (wr),
    .avs_main_writedata     (wdata),
    .avs_main_waitrequest   (wait0),
    .avs_main_readdata      (rdata0),
    .avs_main_readdatavalid (rdv0),
    .avs_main_response      (resp0)
  );

  avalon_main_responder #(
    .MemWords    (4096),
    .ReadLatency (4),
    .MaxPending  (2)
  ) u1 (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .avs_main_address       (addr),
    .avs_main_byteenable    (be),
    .avs_main_read          (rd),
    .avs_main_write         (wr),
    .avs_main_writedata     (wdata),
    .avs_main_waitrequest   (wait1),
    .avs_main_readdata      (rdata1),
    .avs_main_readdatavalid (rdv1),
    .avs_main_response      (resp1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; presents one write cycle.
  task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    wr = 1'b1; rd = 1'b0; addr = a; wdata = d; be = b;
    @(negedge clk);
    idle();
  endtask

  // Called at a negedge; single read on u0 with a latency-2 pulse check.
  task automatic read_u0(input logic [31:0] a, input logic [31:0] expd, input logic [1:0] expr,
                         input string tag);
    rd = 1'b1; addr = a;
    #1 chk({tag, "_wait"}, wait0, 0);
    @(negedge clk);
    idle();
    chk({tag, "_early"}, rdv0, 0);
    @(negedge clk);
    chk({tag, "_rdv"}, rdv0, 1);
    chk({tag, "_data"}, rdata0, expd);
    chk({tag, "_resp"}, resp0, expr);
    @(negedge clk);
    chk({tag, "_pulse"}, rdv0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    chk("rst_rdv0", rdv0, 0);
    chk("rst_data0", rdata0, 0);
    chk("rst_resp0", resp0, 0);
    chk("rst_rdv1", rdv1, 0);
    rd = 1'b1;
    #1 chk("rst_wait0", wait0, 0);
    rd = 1'b0;

    // Basic write then read
    write_word(32'd5, 32'hDEADBEEF, 4'hF);
    read_u0(32'd5, 32'hDEADBEEF, 2'b00, "rw5");

    // Byte lanes
    write_word(32'd7, 32'h11223344, 4'hF);
    write_word(32'd7, 32'hAABBCCDD, 4'b0101);
    read_u0(32'd7, 32'h11BB33DD, 2'b00, "lanes");

    // Out-of-range reads and writes; 4096 would alias word 0 if the range check were lost
    write_word(32'd0, 32'h01020304, 4'hF);
    write_word(32'd1, 32'h0A0B0C0D, 4'hF);
    read_u0(32'd4096, 32'h0, 2'b10, "oor_4096");
    read_u0(32'h80000001, 32'h0, 2'b10, "oor_hi");
    write_word(32'd4096, 32'hFFFFFFFF, 4'hF);
    write_word(32'h80000001, 32'hFFFFFFFF, 4'hF);
    write_word(32'd1, 32'h0, 4'h0);
    read_u0(32'd0, 32'h01020304, 2'b00, "oor_keep0");
    read_u0(32'd1, 32'h0A0B0C0D, 2'b00, "oor_keep1");

    // Read and write together: write wins, read vanishes
    rd = 1'b1; wr = 1'b1; addr = 32'd3; wdata = 32'h5; be = 4'hF;
    #1 chk("coll_wait", wait0, 0);
    @(negedge clk);
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("coll_no_rdv", rdv0, 0);
      @(negedge clk);
    end
    read_u0(32'd3, 32'h5, 2'b00, "coll_rd");
    cyc(8);

    // Stall on u1: MaxPending=2, ReadLatency=4
    for (int i = 0; i < 6; i++) write_word(i, 32'h100 + i, 4'hF);
    exp_rdv_mask  = 18'b00_1100_0110_0011_0000;
    exp_wait_mask = 18'b00_0000_0011_1001_1100;
    issued = 0;
    got = 0;
    for (int c = 0; c < 18; c++) begin
      chk("stall_rdv", rdv1, exp_rdv_mask[c]);
      if (rdv1) begin
        chk("stall_data", rdata1, 32'h100 + got);
        got++;
      end
      if (issued < 6) begin
        rd = 1'b1; addr = issued;
        #1 chk("stall_wait", wait1, exp_wait_mask[c]);
        if (!wait1) issued++;
      end else begin
        idle();
      end
      @(negedge clk);
    end
    idle();
    chk("stall_count", got, 6);

    // pending back at 0: two reads accepted, the third stalls
    rd = 1'b1; addr = 32'd0;
    #1 chk("pend0_a", wait1, 0);
    @(negedge clk);
    #1 chk("pend0_b", wait1, 0);
    @(negedge clk);
    #1 chk("pend0_full", wait1, 1);
    idle();
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdv1) got++;
    end
    chk("pend0_pulses", got, 2);

    // Reset with two reads in flight on u1; a read held during reset must be ignored
    write_word(32'd9, 32'hCAFEF00D, 4'hF);
    cyc(2);
    rd = 1'b1; addr = 32'd9;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("rst_mid_data1", rdata1, 0);
    chk("rst_mid_resp1", resp1, 0);
    chk("rst_mid_rdv0", rdv0, 0);
    got = 0;
    for (int i = 0; i < 8; i++) begin
      if (rdv1) got++;
      @(negedge clk);
    end
    chk("rst_mid_no_rdv", got, 0);
    rd = 1'b1; addr = 32'd9;
    #1 chk("rst_pend_a", wait1, 0);
    @(negedge clk);
    #1 chk("rst_pend_b", wait1, 0);
    @(negedge clk);
    idle();
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (rdv1) begin
        chk("rst_keep_data", rdata1, 32'hCAFEF00D);
        got++;
      end
      @(negedge clk);
    end
    chk("rst_keep_pulses", got, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
